// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and defaults for the pipeline hazard/forwarding unit.
//   fwd_sel_e     - per-operand EX forwarding select encoding
//   REG_AW_DEFAULT - default register-index width
package hazard_pkg;

  localparam int REG_AW_DEFAULT = 5;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,  // operand comes from the register file
    FWD_MEM  = 2'd1,  // operand comes from the MEM-stage result
    FWD_WB   = 2'd2   // operand comes from the WB-stage result
  } fwd_sel_e;

endpackage

// File: rtl/hazard_unit_if.sv
// hazard_unit_if: pipeline-side bundle of the hazard/forwarding controller.
//   master - pipeline registers: drive stage indices/enables, consume selects and stalls
//   slave  - hazard_unit: consumes stage information, drives forwarding and stall controls
// Packed source buses hold operand k at bits [k*REG_AW +: REG_AW].
interface hazard_unit_if #(
  parameter int REG_AW  = hazard_pkg::REG_AW_DEFAULT,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
);
  logic [NUM_SRC*REG_AW-1:0] id_src;
  logic                      id_hilo;
  logic [NUM_SRC*REG_AW-1:0] ex_src;
  logic [REG_AW-1:0]         ex_rd;
  logic [REG_AW-1:0]         mem_rd;
  logic [REG_AW-1:0]         wb_rd;
  logic                      ex_we;
  logic                      mem_we;
  logic                      wb_we;
  logic                      ex_is_load;
  logic                      md_start;
  logic                      stat_clr;
  logic [NUM_SRC*2-1:0]      fwd_sel;
  logic                      stall;
  logic                      flush_ex;
  logic                      md_busy;
  logic [CNT_W-1:0]          stall_cycles;

  modport master (
    output id_src, id_hilo, ex_src, ex_rd, mem_rd, wb_rd,
           ex_we, mem_we, wb_we, ex_is_load, md_start, stat_clr,
    input  fwd_sel, stall, flush_ex, md_busy, stall_cycles
  );

  modport slave (
    input  id_src, id_hilo, ex_src, ex_rd, mem_rd, wb_rd,
           ex_we, mem_we, wb_we, ex_is_load, md_start, stat_clr,
    output fwd_sel, stall, flush_ex, md_busy, stall_cycles
  );
endinterface

// File: rtl/fwd_match.sv
// fwd_match: forwarding select for one EX source operand.
//   src            - operand register index in EX
//   mem_rd, mem_we - MEM-stage destination and write enable
//   wb_rd, wb_we   - WB-stage destination and write enable
//   sel            - FWD_MEM / FWD_WB / FWD_NONE; MEM is younger so it wins.
// Register 0 is hardwired zero and is never forwarded.
module fwd_match
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_we,
  output fwd_sel_e          sel
);

  always_comb begin
    // NOTE: default first so every path assigns sel; otherwise a latch is inferred.
    sel = FWD_NONE;
    if (src != '0) begin
      if (mem_we && (src == mem_rd))     sel = FWD_MEM;
      else if (wb_we && (src == wb_rd))  sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: forwarding selects, load-use and multiply/divide hazard stalls,
// and a saturating stall-cycle counter for the five-stage pipeline.
//   clk, rst_n - rising-edge clock, asynchronous active-low reset
//   hz (slave) - stage indices/enables in; fwd_sel, stall, flush_ex,
//                md_busy, stall_cycles out
// fwd_sel/stall/flush_ex are combinational; md_busy comes straight off the
// MD latency counter so it drops as soon as reset asserts.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW  = REG_AW_DEFAULT,
  parameter int NUM_SRC = 2,
  parameter int MD_LAT  = 4,
  parameter int CNT_W   = 16
) (
  input logic         clk,
  input logic         rst_n,
  hazard_unit_if.slave hz
);

  localparam int MD_W = $clog2(MD_LAT + 1);

  fwd_sel_e           sel [NUM_SRC];
  logic [NUM_SRC-1:0] use_hit;
  logic [MD_W-1:0]    md_cnt;
  logic [CNT_W-1:0]   stall_cnt;
  logic               luse;
  logic               mdh;
  logic               stall;

  // One forwarding matcher per EX operand; the same loop compares the ID
  // operands against the EX destination for the load-use check.
  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    fwd_match #(.REG_AW(REG_AW)) u_fwd (
      .src    (hz.ex_src[k*REG_AW +: REG_AW]),
      .mem_rd (hz.mem_rd),
      .mem_we (hz.mem_we),
      .wb_rd  (hz.wb_rd),
      .wb_we  (hz.wb_we),
      .sel    (sel[k])
    );
    assign hz.fwd_sel[2*k +: 2] = sel[k];
    assign use_hit[k] = (hz.id_src[k*REG_AW +: REG_AW] == hz.ex_rd);
  end

  // A load to r0 produces nothing to wait for.
  assign luse  = hz.ex_we & hz.ex_is_load & (hz.ex_rd != '0) & (|use_hit);
  // md_start covers the issue cycle itself, before the counter is loaded.
  assign mdh   = hz.id_hilo & ((md_cnt != '0) | hz.md_start);
  assign stall = luse | mdh;

  assign hz.stall        = stall;
  assign hz.flush_ex     = stall;
  assign hz.md_busy      = (md_cnt != '0);
  assign hz.stall_cycles = stall_cnt;

  // A new issue restarts the full latency even if the unit is still busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      md_cnt <= '0;
    end else if (hz.md_start) begin
      md_cnt <= MD_W'(MD_LAT);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - MD_W'(1);
    end
  end

  // Clear has priority over counting; the counter sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (hz.stat_clr) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed and randomized checks of hazard_unit against a
// cycle-indexed reference model. A second instance with a 2-bit stall counter
// shares the same stimulus to exercise saturation.
module tb_hazard_unit;
  import hazard_pkg::*;

  localparam int AW    = 5;
  localparam int NS    = 2;
  localparam int LAT   = 4;
  localparam int CW    = 16;
  localparam int CW_S  = 2;

  logic clk;
  logic rst_n;

  hazard_unit_if #(.REG_AW(AW), .NUM_SRC(NS), .CNT_W(CW))   hz ();
  hazard_unit_if #(.REG_AW(AW), .NUM_SRC(NS), .CNT_W(CW_S)) hz_s ();

  hazard_unit #(.REG_AW(AW), .NUM_SRC(NS), .MD_LAT(LAT), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  hazard_unit #(.REG_AW(AW), .NUM_SRC(NS), .MD_LAT(LAT), .CNT_W(CW_S)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz_s)
  );

  assign hz_s.id_src     = hz.id_src;
  assign hz_s.id_hilo    = hz.id_hilo;
  assign hz_s.ex_src     = hz.ex_src;
  assign hz_s.ex_rd      = hz.ex_rd;
  assign hz_s.mem_rd     = hz.mem_rd;
  assign hz_s.wb_rd      = hz.wb_rd;
  assign hz_s.ex_we      = hz.ex_we;
  assign hz_s.mem_we     = hz.mem_we;
  assign hz_s.wb_we      = hz.wb_we;
  assign hz_s.ex_is_load = hz.ex_is_load;
  assign hz_s.md_start   = hz.md_start;
  assign hz_s.stat_clr   = hz.stat_clr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: cycle number, cycle of the most recent MD issue edge,
  // and stall counts as plain integers.
  int cyc;
  int md_last;
  int cnt_big;
  int cnt_small;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [AW-1:0] src_of(input logic [NS*AW-1:0] bus, input int k);
    return bus[k*AW +: AW];
  endfunction

  function automatic bit model_busy();
    return (cyc > md_last) && (cyc <= md_last + LAT);
  endfunction

  function automatic bit model_stall();
    bit luse = 1'b0;
    for (int k = 0; k < NS; k++)
      if (hz.ex_we && hz.ex_is_load && hz.ex_rd != 0 && src_of(hz.id_src, k) == hz.ex_rd)
        luse = 1'b1;
    return luse || (hz.id_hilo && (model_busy() || hz.md_start));
  endfunction

  function automatic logic [NS*2-1:0] model_fwd();
    logic [NS*2-1:0] f = '0;
    for (int k = 0; k < NS; k++) begin
      logic [AW-1:0] s = src_of(hz.ex_src, k);
      if (s != 0 && hz.mem_we && s == hz.mem_rd)    f[2*k +: 2] = 2'd1;
      else if (s != 0 && hz.wb_we && s == hz.wb_rd) f[2*k +: 2] = 2'd2;
    end
    return f;
  endfunction

  task automatic model_reset();
    md_last   = -100;
    cnt_big   = 0;
    cnt_small = 0;
  endtask

  task automatic compare_all();
    bit st = model_stall();
    check("fwd_sel",      32'(hz.fwd_sel),        32'(model_fwd()));
    check("stall",        32'(hz.stall),          32'(st));
    check("flush_ex",     32'(hz.flush_ex),       32'(st));
    check("md_busy",      32'(hz.md_busy),        32'(model_busy()));
    check("stall_cycles", 32'(hz.stall_cycles),   32'(cnt_big));
    check("stall_sat",    32'(hz_s.stall_cycles), 32'(cnt_small));
  endtask

  // Check outputs mid-cycle, away from the rising edge.
  task automatic sample();
    @(negedge clk);
    compare_all();
  endtask

  // Advance one rising edge, updating the model from the inputs held there.
  task automatic tick();
    bit st;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      st = model_stall();
      if (hz.stat_clr) begin
        cnt_big   = 0;
        cnt_small = 0;
      end else if (st) begin
        if (cnt_big < (1 << CW) - 1)     cnt_big++;
        if (cnt_small < (1 << CW_S) - 1) cnt_small++;
      end
      if (hz.md_start) md_last = cyc;
    end
    cyc++;
    #1;
  endtask

  task automatic set_idle();
    hz.id_src     = '0;
    hz.id_hilo    = 1'b0;
    hz.ex_src     = '0;
    hz.ex_rd      = '0;
    hz.mem_rd     = '0;
    hz.wb_rd      = '0;
    hz.ex_we      = 1'b0;
    hz.mem_we     = 1'b0;
    hz.wb_we      = 1'b0;
    hz.ex_is_load = 1'b0;
    hz.md_start   = 1'b0;
    hz.stat_clr   = 1'b0;
  endtask

  task automatic load_use_r8();
    set_idle();
    hz.ex_we           = 1'b1;
    hz.ex_is_load      = 1'b1;
    hz.ex_rd           = 5'd8;
    hz.id_src[AW +: AW] = 5'd8;
  endtask

  initial begin
    cyc = 0;
    model_reset();
    set_idle();
    rst_n = 1'b0;
    tick();
    tick();
    sample();
    check("rst_md_busy", 32'(hz.md_busy), 32'd0);
    check("rst_cnt",     32'(hz.stall_cycles), 32'd0);
    tick();
    rst_n = 1'b1;

    // Forwarding priority and register-0 exclusion.
    hz.ex_src[0 +: AW] = 5'd5;
    hz.mem_rd = 5'd5; hz.mem_we = 1'b1;
    hz.wb_rd  = 5'd5; hz.wb_we  = 1'b1;
    sample(); check("fwd_mem_over_wb", 32'(hz.fwd_sel[1:0]), 32'd1); tick();
    hz.mem_we = 1'b0;
    sample(); check("fwd_wb", 32'(hz.fwd_sel[1:0]), 32'd2); tick();
    hz.mem_we = 1'b1; hz.ex_src[0 +: AW] = 5'd0;
    sample(); check("fwd_r0", 32'(hz.fwd_sel[1:0]), 32'd0); tick();
    hz.ex_src[AW +: AW] = 5'd9; hz.wb_rd = 5'd9;
    sample(); check("fwd_op1_wb", 32'(hz.fwd_sel[3:2]), 32'd2); tick();

    // Load-use: one-cycle stall, none once the load has moved on or targets r0.
    load_use_r8();
    sample(); check("luse_stall", 32'(hz.stall), 32'd1); check("luse_flush", 32'(hz.flush_ex), 32'd1); tick();
    hz.ex_is_load = 1'b0; hz.ex_we = 1'b0; hz.mem_rd = 5'd8; hz.mem_we = 1'b1;
    sample(); check("luse_released", 32'(hz.stall), 32'd0); tick();
    set_idle(); hz.ex_we = 1'b1; hz.ex_is_load = 1'b1;
    sample(); check("luse_r0", 32'(hz.stall), 32'd0); tick();

    // MD issue with a HI/LO reader held in ID.
    set_idle(); hz.stat_clr = 1'b1; sample(); tick();
    hz.stat_clr = 1'b0; hz.id_hilo = 1'b1; hz.md_start = 1'b1;
    sample(); check("md_issue_stall", 32'(hz.stall), 32'd1); check("md_issue_busy", 32'(hz.md_busy), 32'd0); tick();
    hz.md_start = 1'b0;
    for (int i = 1; i <= LAT; i++) begin
      sample(); check("md_busy_win", 32'(hz.md_busy), 32'd1); check("md_stall_win", 32'(hz.stall), 32'd1); tick();
    end
    sample(); check("md_done_busy", 32'(hz.md_busy), 32'd0); check("md_done_stall", 32'(hz.stall), 32'd0);
    check("md_stall_count", 32'(hz.stall_cycles), 32'(LAT + 1)); tick();

    // Reissue while busy restarts the latency.
    set_idle(); hz.md_start = 1'b1; sample(); tick();
    hz.md_start = 1'b0; sample(); tick();
    hz.md_start = 1'b1; sample(); check("reissue_busy", 32'(hz.md_busy), 32'd1); tick();
    hz.md_start = 1'b0;
    for (int i = 1; i <= LAT; i++) begin
      sample(); check("reissue_hold", 32'(hz.md_busy), 32'd1); tick();
    end
    sample(); check("reissue_done", 32'(hz.md_busy), 32'd0); tick();

    // Stall counter: clear, counting, clear-beats-stall, saturation.
    set_idle(); hz.stat_clr = 1'b1; sample(); tick();
    load_use_r8();
    for (int i = 0; i < 3; i++) begin sample(); tick(); end
    hz.stat_clr = 1'b1;
    sample(); check("cnt_three", 32'(hz.stall_cycles), 32'd3); check("cnt_sat_three", 32'(hz_s.stall_cycles), 32'd3); tick();
    load_use_r8();
    sample(); check("cnt_clr_wins", 32'(hz.stall_cycles), 32'd0); tick();
    for (int i = 0; i < 4; i++) begin sample(); tick(); end
    set_idle();
    sample(); check("cnt_five", 32'(hz.stall_cycles), 32'd5); check("cnt_saturated", 32'(hz_s.stall_cycles), 32'd3); tick();

    // Reset in the middle of an MD operation.
    set_idle(); hz.md_start = 1'b1; sample(); tick();
    hz.md_start = 1'b0; sample(); tick();
    rst_n = 1'b0; #1;
    check("rst_mid_busy", 32'(hz.md_busy), 32'd0);
    check("rst_mid_cnt",  32'(hz.stall_cycles), 32'd0);
    hz.id_hilo = 1'b1;
    tick();
    rst_n = 1'b1;
    sample(); check("rst_no_stall", 32'(hz.stall), 32'd0); tick();

    // Randomized traffic over a small register range to provoke matches.
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < NS; k++) begin
        hz.id_src[k*AW +: AW] = AW'($urandom_range(0, 7));
        hz.ex_src[k*AW +: AW] = AW'($urandom_range(0, 7));
      end
      hz.ex_rd      = AW'($urandom_range(0, 7));
      hz.mem_rd     = AW'($urandom_range(0, 7));
      hz.wb_rd      = AW'($urandom_range(0, 7));
      hz.ex_we      = 1'($urandom_range(0, 1));
      hz.mem_we     = 1'($urandom_range(0, 1));
      hz.wb_we      = 1'($urandom_range(0, 1));
      hz.ex_is_load = 1'($urandom_range(0, 1));
      hz.id_hilo    = ($urandom_range(0, 2) == 0);
      hz.md_start   = ($urandom_range(0, 7) == 0);
      hz.stat_clr   = ($urandom_range(0, 15) == 0);
      sample();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Parametrised hazard and forwarding controller for the five-stage pipeline. Produces per-operand EX forwarding selects for NUM_SRC source operands, detects load-use hazards in ID and stalls one cycle, and tracks the multi-cycle multiply/divide unit with a latency counter that stalls HI/LO readers and back-to-back MD ops. A saturating stall-cycle counter is kept for performance monitoring. Sits between the ID/EX/MEM/WB pipeline registers and the PC/IF-ID enables.

## Interface
- REG_AW, 5, register-index width
- NUM_SRC, 2, source operands per instruction (packed buses, operand k at bits [k*REG_AW +: REG_AW])
- MD_LAT, 4, multiply/divide latency in cycles after issue (≥1)
- CNT_W, 16, stall counter width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- id_src  in  NUM_SRC*REG_AW  source indices of instruction in ID
- id_hilo  in  1  ID instruction reads HI/LO or is itself an MD op
- ex_src  in  NUM_SRC*REG_AW  source indices of instruction in EX
- ex_rd, mem_rd, wb_rd  in  REG_AW each  destination indices
- ex_we, mem_we, wb_we  in  1 each  register write enables
- ex_is_load  in  1  EX instruction is a load
- md_start  in  1  MD op issuing from EX this cycle
- stat_clr  in  1  synchronous clear of stall counter
- fwd_sel  out  NUM_SRC*2  per-operand select: 0 register file, 1 MEM result, 2 WB result
- stall  out  1  hold PC and IF/ID register
- flush_ex  out  1  insert bubble into ID/EX register
- md_busy  out  1  MD unit computing
- stall_cycles  out  CNT_W  saturating count of stalled cycles

## Operation
- Forwarding (combinational, per operand k): if ex_src[k]≠0 and mem_we and ex_src[k]==mem_rd → 1; else if ex_src[k]≠0 and wb_we and ex_src[k]==wb_rd → 2; else 0. MEM beats WB when both match.
- Load-use: luse = ex_we & ex_is_load & ex_rd≠0 & (any k: id_src[k]==ex_rd).
- MD hazard: mdh = id_hilo & (md_busy | md_start).
- stall = flush_ex = luse | mdh.
- Register 0 never forwards and never causes a load-use stall.
- MD counter md_cnt, width $clog2(MD_LAT+1): on edge with md_start=1 load MD_LAT (reload even if nonzero); else if nonzero decrement. md_busy = (md_cnt≠0).
- stall_cycles: stat_clr → 0 (priority); else increment when stall=1, holding at all-ones.

## Timing
- Reset: md_cnt=0, stall_cycles=0; hence md_busy=0; fwd_sel/stall/flush_ex are purely combinational from inputs.
- fwd_sel, stall, flush_ex: zero-cycle latency, same cycle as inputs.
- Load-use stall lasts exactly one cycle (load advances to MEM, consumer then takes WB forward).
- MD issue at edge t: md_busy high for cycles t+1..t+MD_LAT, low at t+MD_LAT+1. HI/LO reader in ID stalls in cycle t (via md_start) and t+1..t+MD_LAT; proceeds at t+MD_LAT+1.
- luse and mdh together: single stall, counter increments by one per cycle.
- Reset asserted mid-MD: md_cnt cleared immediately, md_busy drops asynchronously.
- stat_clr and stall same cycle: counter becomes 0.

## Structure
- Package hazard_pkg: FWD_NONE=2'd0, FWD_MEM=2'd1, FWD_WB=2'd2; default REG_AW.
- Sub-module fwd_match (one operand: src, mem_rd/we, wb_rd/we → 2-bit select), instantiated NUM_SRC times in a generate loop; load-use compare reuses the same loop.

## Test plan
- ex_src0=5, mem_rd=5/mem_we=1, wb_rd=5/wb_we=1 → fwd_sel[1:0]=1; drop mem_we → 2; set src=0 with all matching → 0.
- EX lw to r8 (ex_is_load=1, ex_we=1), id_src1=8 → stall=flush_ex=1 one cycle; same with ex_rd=0 → no stall.
- md_start pulse at cycle 10, MD_LAT=4, id_hilo=1 held → stall cycles 10–14, released cycle 15; md_busy high 11–14.
- md_start reissued at cycle 12 during busy → md_busy remains high through cycle 16.
- 3 stalled cycles then stat_clr → stall_cycles 3 then 0; CNT_W=2 with 5 stalls → saturates at 3.
- rst_n low at cycle 2 of MD op → md_busy=0 and stall_cycles=0 immediately, no stall after release with id_hilo=1 and md_start=0.
